// File: rtl/set_ctrl.sv
// Clock/calendar set controller: debounces the mode/up/down buttons, walks the
// edited item, and issues single-cycle up/down pulses with hold-to-repeat and blink.

module set_ctrl_debounce #(
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic clk_1kHz,
  input  logic rst_n,
  input  logic vld_i,
  input  logic btn_i,
  output logic lvl_o
);
  localparam int CW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]    sync_q;
  logic          db_q;
  logic          armed_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      db_q    <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      if (sync_q[1] == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        db_q  <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      // A button held through reset stays masked until it is seen fully released.
      if (vld_i && !sync_q[1] && !db_q) armed_q <= 1'b1;
    end
  end

  assign lvl_o = db_q & armed_q;
endmodule

module set_ctrl #(
  parameter int DEBOUNCE_CYC = 20,
  parameter int HOLD_CYC     = 500,
  parameter int REPEAT_CYC   = 100,
  parameter int TIMEOUT_CYC  = 30000,
  parameter int BLINK_CYC    = 250
) (
  input  logic       clk_1kHz,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [2:0] select_item,
  output logic       up,
  output logic       down,
  output logic       blink
);
  localparam int NUM_BTN = 3;
  localparam int B_MODE  = 0;
  localparam int B_UP    = 1;
  localparam int B_DN    = 2;
  localparam int HMAX    = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int HW      = $clog2(HMAX + 1);
  localparam int IW      = $clog2(TIMEOUT_CYC + 1);
  localparam int BW      = $clog2(BLINK_CYC + 1);

  typedef enum logic [2:0] {
    S_RUN  = 3'd0,
    S_MIN  = 3'd1,
    S_HOUR = 3'd2,
    S_DAY  = 3'd3,
    S_MON  = 3'd4,
    S_YEAR = 3'd5
  } item_e;

  item_e               sel_q;
  logic                up_q, down_q, blink_q, rep_q;
  logic [HW-1:0]       hold_cnt_q;
  logic [IW-1:0]       idle_q;
  logic [BW-1:0]       blink_cnt_q;
  logic [1:0]          vld_pipe_q;
  logic [NUM_BTN-1:0]  btn_raw, lvl, lvl_prev_q, rise;

  // Synchronizer contents are meaningful once two edges have passed since reset.
  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) vld_pipe_q <= '0;
    else        vld_pipe_q <= {vld_pipe_q[0], 1'b1};
  end

  assign btn_raw = {btn_down, btn_up, btn_mode};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    set_ctrl_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk_1kHz (clk_1kHz),
      .rst_n    (rst_n),
      .vld_i    (vld_pipe_q[1]),
      .btn_i    (btn_raw[g]),
      .lvl_o    (lvl[g])
    );
  end

  assign rise = lvl & ~lvl_prev_q;

  logic edit, mode_rise, up_alone, dn_alone, hold_hit, act, timeout;
  logic fire_up_d, fire_dn_d, sel_chg, next_edit;

  always_comb begin
    edit      = (sel_q != S_RUN);
    mode_rise = rise[B_MODE];
    up_alone  = lvl[B_UP] & ~lvl[B_DN];
    dn_alone  = lvl[B_DN] & ~lvl[B_UP];
    hold_hit  = rep_q ? (hold_cnt_q == HW'(REPEAT_CYC - 1))
                      : (hold_cnt_q == HW'(HOLD_CYC - 1));
    // Mode advance outranks any up/down pulse in the same cycle.
    fire_up_d = edit & ~mode_rise & up_alone & (rise[B_UP] | hold_hit);
    fire_dn_d = edit & ~mode_rise & dn_alone & (rise[B_DN] | hold_hit);
    act       = (|rise) | lvl[B_UP] | lvl[B_DN];
    timeout   = edit & ~act & (idle_q == IW'(TIMEOUT_CYC - 1));
    sel_chg   = mode_rise | timeout;
    next_edit = mode_rise & (sel_q != S_YEAR);
  end

  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= S_RUN;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      blink_q     <= 1'b0;
      rep_q       <= 1'b0;
      hold_cnt_q  <= '0;
      idle_q      <= '0;
      blink_cnt_q <= '0;
      lvl_prev_q  <= '0;
    end else begin
      lvl_prev_q <= lvl;
      up_q       <= fire_up_d;
      down_q     <= fire_dn_d;

      if (mode_rise)    sel_q <= (sel_q == S_YEAR) ? S_RUN : item_e'(sel_q + 3'd1);
      else if (timeout) sel_q <= S_RUN;

      // Hold/repeat timer only runs while exactly one of up/down is held.
      if (!edit || sel_chg || !(up_alone || dn_alone)) begin
        hold_cnt_q <= '0;
        rep_q      <= 1'b0;
      end else if (fire_up_d || fire_dn_d) begin
        hold_cnt_q <= '0;
        rep_q      <= ~(rise[B_UP] | rise[B_DN]);
      end else begin
        hold_cnt_q <= hold_cnt_q + 1'b1;
      end

      if (!edit || act || timeout) idle_q <= '0;
      else                         idle_q <= idle_q + 1'b1;

      if (sel_chg) begin
        blink_q     <= next_edit;
        blink_cnt_q <= '0;
      end else if (!edit) begin
        blink_q     <= 1'b0;
        blink_cnt_q <= '0;
      end else if (fire_up_d || fire_dn_d) begin
        blink_q     <= 1'b1;
        blink_cnt_q <= '0;
      end else if (blink_cnt_q == BW'(BLINK_CYC - 1)) begin
        blink_q     <= ~blink_q;
        blink_cnt_q <= '0;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign select_item = sel_q;
  assign up          = up_q;
  assign down        = down_q;
  assign blink       = blink_q;
endmodule

// File: tb/tb_set_ctrl.sv
// Directed bench for set_ctrl with default timing parameters.

module tb_set_ctrl;
  logic       clk_1kHz = 1'b0;
  logic       rst_n;
  logic       btn_mode, btn_up, btn_down;
  logic [2:0] select_item;
  logic       up, down, blink;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int up_cnt = 0;
  int dn_cnt = 0;
  int up_t [64];
  logic both_seen = 1'b0;
  int p, ub, db;

  set_ctrl dut (
    .clk_1kHz    (clk_1kHz),
    .rst_n       (rst_n),
    .btn_mode    (btn_mode),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .select_item (select_item),
    .up          (up),
    .down        (down),
    .blink       (blink)
  );

  always #5 clk_1kHz = ~clk_1kHz;

  always @(posedge clk_1kHz) cyc <= cyc + 1;

  always @(negedge clk_1kHz) begin
    if (up) begin
      up_t[up_cnt % 64] = cyc;
      up_cnt = up_cnt + 1;
    end
    if (down) dn_cnt = dn_cnt + 1;
    if (up && down) both_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_1kHz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; tick(50);
    btn_mode = 1'b0; tick(50);
  endtask

  initial begin
    logic [2:0] mode_seq [5];
    int d;
    mode_seq = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    rst_n = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    tick(3);
    check("rst_sel", select_item, 0);
    check("rst_up", up, 0);
    check("rst_down", down, 0);
    check("rst_blink", blink, 0);
    rst_n = 1'b1;
    tick(5);

    // mode walk, first press timed exactly
    btn_mode = 1'b1; tick(22);
    check("mode_lat22", select_item, 0);
    tick(1);
    check("mode_lat23", select_item, 1);
    check("blink_entry", blink, 1);
    tick(27); btn_mode = 1'b0; tick(50);
    check("mode_1", select_item, 1);
    for (int i = 0; i < 5; i++) begin
      press_mode();
      check($sformatf("mode_%0d", i + 2), select_item, mode_seq[i]);
    end
    check("blink_run", blink, 0);

    // down in RUN does nothing
    db = dn_cnt;
    btn_down = 1'b1; tick(50); btn_down = 1'b0; tick(50);
    check("run_down_cnt", dn_cnt - db, 0);
    check("run_down_sel", select_item, 0);

    repeat (3) press_mode();
    check("sel_day", select_item, 3);

    // hold-to-repeat
    ub = up_cnt; p = cyc;
    btn_up = 1'b1; tick(800); btn_up = 1'b0; tick(50);
    check("rep_count", up_cnt - ub, 4);
    d = up_t[ub % 64] - p;
    tests++;
    assert (d >= 22 && d <= 23) else begin
      fails++;
      $error("FAIL first_up_lat: observed %0d expected 22..23", d);
    end
    check("rep_500", up_t[(ub + 1) % 64] - up_t[ub % 64], 500);
    check("rep_600", up_t[(ub + 2) % 64] - up_t[ub % 64], 600);
    check("rep_700", up_t[(ub + 3) % 64] - up_t[ub % 64], 700);

    // single down pulse in edit state
    ub = up_cnt; db = dn_cnt;
    btn_down = 1'b1; tick(50); btn_down = 1'b0; tick(50);
    check("edit_down_cnt", dn_cnt - db, 1);
    check("edit_down_up", up_cnt - ub, 0);

    // bouncy press
    ub = up_cnt;
    for (int i = 0; i < 12; i++) begin
      btn_up = (i % 2 == 0); tick(5);
    end
    btn_up = 1'b1; tick(100); btn_up = 1'b0; tick(50);
    check("bounce_cnt", up_cnt - ub, 1);

    // both held: suppress, then restart hold count for the survivor
    ub = up_cnt; db = dn_cnt; p = cyc;
    btn_up = 1'b1; tick(100);
    btn_down = 1'b1; tick(100);
    btn_down = 1'b0; tick(550);
    btn_up = 1'b0; tick(50);
    check("both_up_cnt", up_cnt - ub, 2);
    check("both_dn_cnt", dn_cnt - db, 0);
    check("both_restart", up_t[(ub + 1) % 64] - up_t[ub % 64], 699);

    // mode and up in the same cycle
    ub = up_cnt;
    btn_mode = 1'b1; btn_up = 1'b1; tick(50);
    btn_mode = 1'b0; btn_up = 1'b0; tick(50);
    check("tie_sel", select_item, 4);
    check("tie_up_cnt", up_cnt - ub, 0);

    // reset mid auto-repeat, button still held afterwards
    ub = up_cnt;
    btn_up = 1'b1; tick(600);
    check("pre_rst_cnt", up_cnt - ub, 2);
    rst_n = 1'b0; #1;
    check("arst_sel", select_item, 0);
    check("arst_up", up, 0);
    check("arst_down", down, 0);
    check("arst_blink", blink, 0);
    tick(3); rst_n = 1'b1; tick(10);
    ub = up_cnt;
    press_mode();
    check("post_rst_sel", select_item, 1);
    tick(600);
    check("held_thru_rst", up_cnt - ub, 0);
    btn_up = 1'b0; tick(50);
    btn_up = 1'b1; tick(50);
    btn_up = 1'b0; tick(50);
    check("repress_cnt", up_cnt - ub, 1);

    // idle timeout from hour, with blink phase
    btn_mode = 1'b1; tick(23);
    check("to_entry", select_item, 2);
    tick(249);
    check("blink_249", blink, 1);
    tick(1);
    check("blink_250", blink, 0);
    btn_mode = 1'b0;
    tick(29749);
    check("to_29999", select_item, 2);
    tick(1);
    check("to_30000_sel", select_item, 0);
    check("to_30000_blink", blink, 0);

    check("never_both", both_seen, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
